// File: rtl/sample_serializer_if.sv
// Sample-in / byte-out bundle for sample_serializer.
// master = producer/UART side, slave = serializer.
interface sample_serializer_if #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                tx_busy;
  logic                in_en;
  logic [SAMPLE_W-1:0] in_sample;
  logic [7:0]          out_uart_frame;
  logic                out_ready_uart;
  logic                out_ready_sample_switch;
  logic                out_overflow;
  logic [LW-1:0]       out_level;

  modport master (
    output tx_busy, in_en, in_sample,
    input  out_uart_frame, out_ready_uart, out_ready_sample_switch,
           out_overflow, out_level
  );

  modport slave (
    input  tx_busy, in_en, in_sample,
    output out_uart_frame, out_ready_uart, out_ready_sample_switch,
           out_overflow, out_level
  );
endinterface

// File: rtl/sample_serializer.sv
// Buffers wide samples in a small FIFO and feeds them byte by byte to a UART,
// with an optional header byte and a two-idle-cycle guard between strobes.
module sample_serializer #(
  parameter int       SAMPLE_W    = 16,
  parameter int       FIFO_DEPTH  = 4,
  parameter bit       MSB_FIRST   = 1'b0,
  parameter bit       HEADER_EN   = 1'b0,
  parameter bit [7:0] HEADER_BYTE = 8'hFF
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  sample_serializer_if.slave  bus
);
  localparam int BYTES = SAMPLE_W / 8;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, HDR, SEND, WAIT} state_t;

  state_t              state_q, state_d;
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                overflow_q, overflow_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [BIW-1:0]      byte_idx_q, byte_idx_d;
  logic                guard_q, guard_d;
  logic                hdr_done_q, hdr_done_d;
  logic [7:0]          frame_q, frame_d;
  logic                strobe_q, strobe_d;

  logic                full, empty, push, pop;
  logic [BIW-1:0]      k;
  logic [BYTES-1:0][7:0] sample_bytes;

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  assign push  = bus.in_en && !full;

  // The in-flight sample lives in its own register, so later pushes into
  // the FIFO array cannot disturb it.
  assign sample_bytes = sample_q;
  assign k = MSB_FIRST ? (BIW'(BYTES - 1) - byte_idx_q) : byte_idx_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (bus.in_en & full);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    sample_d   = sample_q;
    byte_idx_d = byte_idx_q;
    guard_d    = guard_q;
    hdr_done_d = hdr_done_q;
    frame_d    = frame_q;
    strobe_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !bus.tx_busy) begin
          pop        = 1'b1;
          sample_d   = mem_q[rd_ptr_q];
          byte_idx_d = '0;
          guard_d    = 1'b0;
          hdr_done_d = 1'b0;
          state_d    = HEADER_EN ? HDR : SEND;
        end
      end
      HDR: begin
        frame_d    = HEADER_BYTE;
        strobe_d   = 1'b1;
        hdr_done_d = 1'b1;
        state_d    = WAIT;
      end
      SEND: begin
        frame_d  = sample_bytes[k];
        strobe_d = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        // Leave only after two consecutive idle cycles of the transmitter.
        if (bus.tx_busy) begin
          guard_d = 1'b0;
        end else if (!guard_q) begin
          guard_d = 1'b1;
        end else begin
          guard_d = 1'b0;
          if (hdr_done_q) begin
            hdr_done_d = 1'b0;
            byte_idx_d = '0;
            state_d    = SEND;
          end else if (byte_idx_q != BIW'(BYTES - 1)) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_sample;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      sample_q   <= '0;
      byte_idx_q <= '0;
      guard_q    <= 1'b0;
      hdr_done_q <= 1'b0;
      frame_q    <= 8'h00;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      sample_q   <= sample_d;
      byte_idx_q <= byte_idx_d;
      guard_q    <= guard_d;
      hdr_done_q <= hdr_done_d;
      frame_q    <= frame_d;
      strobe_q   <= strobe_d;
    end
  end

  assign bus.out_uart_frame          = frame_q;
  assign bus.out_ready_uart          = strobe_q;
  assign bus.out_ready_sample_switch = !full;
  assign bus.out_overflow            = overflow_q;
  assign bus.out_level               = level_q;
endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench: two serializer configurations, expected byte streams
// built from pushed samples, checked by independent negedge monitors.
module tb_sample_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  sample_serializer_if #(.SAMPLE_W(16), .FIFO_DEPTH(4)) a_if ();
  sample_serializer_if #(.SAMPLE_W(24), .FIFO_DEPTH(4)) b_if ();

  sample_serializer #(.SAMPLE_W(16), .FIFO_DEPTH(4), .MSB_FIRST(1'b0),
                      .HEADER_EN(1'b0), .HEADER_BYTE(8'hFF))
    dut_a (.in_clk(clk), .in_rst_n(rst_n), .bus(a_if.slave));

  sample_serializer #(.SAMPLE_W(24), .FIFO_DEPTH(4), .MSB_FIRST(1'b1),
                      .HEADER_EN(1'b1), .HEADER_BYTE(8'hFF))
    dut_b (.in_clk(clk), .in_rst_n(rst_n), .bus(b_if.slave));

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int stamps_a[$];
  int stamps_b[$];
  int last_a = -1;
  int last_b = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: LSB-first bytes, no header.
  task automatic model_push_a(input logic [15:0] s);
    for (int i = 0; i < 2; i++) exp_a.push_back(8'((s >> (8 * i)) & 16'hFF));
  endtask

  // Reference: header then MSB-first bytes.
  task automatic model_push_b(input logic [23:0] s);
    exp_b.push_back(8'hFF);
    for (int i = 2; i >= 0; i--) exp_b.push_back(8'((s >> (8 * i)) & 24'hFF));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input int n, input int budget);
    int k = 0;
    while (stamps_a.size() < n && k < budget) begin tick(); k++; end
    if (stamps_a.size() < n) fail_now("a_timeout", stamps_a.size(), n);
  endtask

  task automatic wait_b(input int n, input int budget);
    int k = 0;
    while (stamps_b.size() < n && k < budget) begin tick(); k++; end
    if (stamps_b.size() < n) fail_now("b_timeout", stamps_b.size(), n);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_if.out_ready_uart) begin
        if (exp_a.size() == 0) fail_now("a_unexpected_strobe", a_if.out_uart_frame, 0);
        else chk("a_byte", a_if.out_uart_frame, exp_a.pop_front());
        if (last_a >= 0) chk("a_spacing_ge3", (cyc - last_a) >= 3, 1);
        last_a = cyc;
        stamps_a.push_back(cyc);
      end
      if (b_if.out_ready_uart) begin
        if (exp_b.size() == 0) fail_now("b_unexpected_strobe", b_if.out_uart_frame, 0);
        else chk("b_byte", b_if.out_uart_frame, exp_b.pop_front());
        if (last_b >= 0) chk("b_spacing_ge3", (cyc - last_b) >= 3, 1);
        last_b = cyc;
        stamps_b.push_back(cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int k;
    a_if.tx_busy = 1'b0; a_if.in_en = 1'b0; a_if.in_sample = '0;
    b_if.tx_busy = 1'b0; b_if.in_en = 1'b0; b_if.in_sample = '0;
    repeat (3) tick();

    chk("rst_frame",    a_if.out_uart_frame, 8'h00);
    chk("rst_strobe",   a_if.out_ready_uart, 0);
    chk("rst_overflow", a_if.out_overflow, 0);
    chk("rst_level",    a_if.out_level, 0);
    chk("rst_switch",   a_if.out_ready_sample_switch, 1);
    chk("rst_b_level",  b_if.out_level, 0);
    rst_n = 1'b1;
    tick();

    // LSB-first 16-bit sample: latency 2, spacing 3
    stamps_a.delete();
    a_if.in_en = 1'b1; a_if.in_sample = 16'hA55A; model_push_a(16'hA55A);
    tick(); p = cyc; a_if.in_en = 1'b0;
    wait_a(2, 30);
    if (stamps_a.size() >= 2) begin
      chk("a_latency", stamps_a[0] - p, 2);
      chk("a_spacing", stamps_a[1] - stamps_a[0], 3);
    end
    repeat (6) tick();
    chk("a_level_after", a_if.out_level, 0);

    // 24-bit MSB-first sample with header
    stamps_b.delete();
    b_if.in_en = 1'b1; b_if.in_sample = 24'h123456; model_push_b(24'h123456);
    tick(); p = cyc; b_if.in_en = 1'b0;
    wait_b(4, 40);
    if (stamps_b.size() >= 4) begin
      chk("b_latency", stamps_b[0] - p, 2);
      chk("b_spacing", stamps_b[3] - stamps_b[2], 3);
    end
    chk("b_drained", exp_b.size(), 0);

    // Guard pattern 0,1,0,0 in WAIT stretches spacing to 5
    stamps_a.delete();
    a_if.in_en = 1'b1; a_if.in_sample = 16'h1234; model_push_a(16'h1234);
    tick(); a_if.in_en = 1'b0;
    tick(); tick();
    tick(); a_if.tx_busy = 1'b1;
    tick(); a_if.tx_busy = 1'b0;
    wait_a(2, 20);
    if (stamps_a.size() >= 2) chk("a_guard_spacing", stamps_a[1] - stamps_a[0], 5);
    repeat (6) tick();

    // Overflow: busy UART, five pushes into a four-deep buffer
    a_if.tx_busy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      a_if.in_en = 1'b1; a_if.in_sample = 16'h1100 + 16'(i * 16'h0101);
      if (i < 4) model_push_a(a_if.in_sample);
      tick();
      if (i == 3) begin
        chk("ovf_level4",  a_if.out_level, 4);
        chk("ovf_switch0", a_if.out_ready_sample_switch, 0);
        chk("ovf_not_yet", a_if.out_overflow, 0);
      end
    end
    a_if.in_en = 1'b0;
    chk("ovf_flag",  a_if.out_overflow, 1);
    chk("ovf_level", a_if.out_level, 4);
    a_if.tx_busy = 1'b0;
    stamps_a.delete();
    wait_a(8, 200);
    repeat (8) tick();
    chk("ovf_drained", exp_a.size(), 0);
    chk("ovf_sticky", a_if.out_overflow, 1);

    // Reset between byte 0 and byte 1 of 16'hBEEF
    stamps_a.delete();
    a_if.in_en = 1'b1; a_if.in_sample = 16'hBEEF; model_push_a(16'hBEEF);
    tick(); a_if.in_en = 1'b0;
    wait_a(1, 20);
    rst_n = 1'b0;
    exp_a.delete(); exp_b.delete(); last_a = -1; last_b = -1;
    tick();
    chk("mid_rst_frame",    a_if.out_uart_frame, 8'h00);
    chk("mid_rst_strobe",   a_if.out_ready_uart, 0);
    chk("mid_rst_overflow", a_if.out_overflow, 0);
    chk("mid_rst_level",    a_if.out_level, 0);
    chk("mid_rst_switch",   a_if.out_ready_sample_switch, 1);
    tick();
    rst_n = 1'b1;
    a_if.in_en = 1'b1; a_if.in_sample = 16'h1357; model_push_a(16'h1357);
    tick(); a_if.in_en = 1'b0;
    chk("first_push_level", a_if.out_level, 1);
    stamps_a.delete();
    wait_a(2, 30);
    repeat (10) tick();
    chk("post_rst_drained", exp_a.size(), 0);

    // Randomized traffic on both instances
    for (int i = 0; i < 1500; i++) begin
      a_if.tx_busy = ($urandom % 4) == 0;
      b_if.tx_busy = ($urandom % 4) == 0;
      a_if.in_en = (($urandom % 3) == 0) && a_if.out_ready_sample_switch;
      b_if.in_en = (($urandom % 3) == 0) && b_if.out_ready_sample_switch;
      a_if.in_sample = 16'($urandom);
      b_if.in_sample = 24'($urandom);
      if (a_if.in_en) model_push_a(a_if.in_sample);
      if (b_if.in_en) model_push_b(b_if.in_sample);
      tick();
    end
    a_if.in_en = 1'b0; b_if.in_en = 1'b0;
    a_if.tx_busy = 1'b0; b_if.tx_busy = 1'b0;
    k = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 400) begin tick(); k++; end
    repeat (10) tick();
    chk("rand_a_drained", exp_a.size(), 0);
    chk("rand_b_drained", exp_b.size(), 0);
    chk("rand_no_overflow_a", a_if.out_overflow, 0);
    chk("rand_no_overflow_b", b_if.out_overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sample_serializer.md
SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 Parameter: SAMPLE_W, 16, sample width in bits; SHALL be a multiple of 8 in the range 8..64.
REQ-002 Parameter: FIFO_DEPTH, 4, sample buffer depth in entries; SHALL be a power of 2, minimum 2.
REQ-003 Parameter: MSB_FIRST, 0, byte order; 0 = least-significant byte first, 1 = most-significant byte first.
REQ-004 Parameter: HEADER_EN, 0, 1 = send HEADER_BYTE before each sample's bytes.
REQ-005 Parameter: HEADER_BYTE, 8'hFF, value of the header byte.
REQ-006 Derived: BYTES = SAMPLE_W/8.
REQ-007 Port: in_clk  in  1  sole clock; all logic on rising edge.
REQ-008 Port: in_rst_n  in  1  asynchronous, active-low reset.
REQ-009 Port: tx_busy  in  1  UART transmitter busy.
REQ-010 Port: in_en  in  1  sample-valid strobe; write request.
REQ-011 Port: in_sample  in  SAMPLE_W  sample data.
REQ-012 Port: out_uart_frame  out  8  byte presented to the UART.
REQ-013 Port: out_ready_uart  out  1  one-cycle send strobe for out_uart_frame.
REQ-014 Port: out_ready_sample_switch  out  1  buffer not full; a sample can be accepted.
REQ-015 Port: out_overflow  out  1  sticky flag; set when a sample is dropped.
REQ-016 Port: out_level  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-017 Push: when in_en=1 and the buffer is not full (judged on the pre-edge state), in_sample SHALL be written.
REQ-018 Drop: when in_en=1 and the buffer is full, the sample SHALL be discarded, buffer contents SHALL be unchanged, and out_overflow SHALL be set.
- out_overflow clears only on reset.
REQ-019 Simultaneous push and pop in one cycle (buffer not full) SHALL leave out_level unchanged; both operations take effect.
REQ-020 out_ready_sample_switch SHALL equal (out_level != FIFO_DEPTH), driven combinationally from the registered level.
REQ-021 The FSM SHALL have states IDLE, HDR, SEND and WAIT.
REQ-022 IDLE: if the buffer is non-empty and tx_busy=0, the FSM SHALL pop the head into a shift register, clear byte_idx, and go to HDR if HEADER_EN=1, else to SEND.
- Otherwise it remains in IDLE.
REQ-023 HDR: out_uart_frame<=HEADER_BYTE, out_ready_uart<=1, mark header done, go to WAIT.
REQ-024 SEND: out_uart_frame<=byte k, out_ready_uart<=1, go to WAIT.
- k = byte_idx when MSB_FIRST=0; k = BYTES-1-byte_idx when MSB_FIRST=1.
- Byte k = sample[8k+7:8k].
REQ-025 out_ready_uart SHALL be high for exactly one cycle per byte.
- out_uart_frame SHALL hold its value until the next HDR/SEND.
REQ-026 WAIT: a 1-bit guard counter SHALL advance on each cycle with tx_busy=0 and SHALL clear on any cycle with tx_busy=1.
- On the 2nd consecutive tx_busy=0 cycle, the FSM leaves WAIT and the guard clears.
REQ-027 WAIT exit: after the header -> SEND with byte_idx=0; after byte_idx < BYTES-1 -> SEND with byte_idx+1; after the last byte -> IDLE.
REQ-028 Minimum inter-strobe spacing SHALL be 3 cycles; minimum sample-to-first-strobe latency from IDLE SHALL be 2 cycles.
REQ-029 Samples SHALL be emitted in arrival order; wrap-around of the read and write pointers SHALL be transparent.
REQ-030 Samples pushed while the FSM is serialising SHALL NOT alter the sample in flight.

Reset
REQ-031 While in_rst_n=0, regardless of clock, the block SHALL hold:
- state=IDLE, buffer empty, out_level=0;
- out_uart_frame=8'h00, out_ready_uart=0, out_overflow=0, out_ready_sample_switch=1;
- guard and byte_idx = 0.
REQ-032 Reset asserted mid-sample SHALL abort the transfer; no further strobe for that sample after release.
REQ-033 The first push SHALL be accepted on the first rising edge after in_rst_n deasserts.

Verification
REQ-034 SAMPLE_W=16, MSB_FIRST=0, tx_busy=0: push 16'hA55A -> strobes carrying 8'h5A then 8'hA5, spaced 3 cycles; then IDLE.
REQ-035 SAMPLE_W=24, MSB_FIRST=1, HEADER_EN=1: push 24'h123456 -> strobes FF, 12, 34, 56.
REQ-036 FIFO_DEPTH=4, tx_busy held 1: push 5 samples -> out_level=4, out_ready_sample_switch=0 after the 4th, out_overflow=1, 5th lost; release tx_busy -> first 4 emitted in order.
REQ-037 In WAIT, tx_busy pattern 0,1,0,0 -> next strobe only after the final two low cycles.
REQ-038 Reset pulse between byte 0 and byte 1 of 16'hBEEF -> no 8'hBE strobe; all outputs at reset values; a new push works.
